// File: rtl/sha2_miner_pkg.sv
// sha2_miner_pkg: shared types and helpers for the sha256 mining driver.
// Driver FSM states, padded-length helper, all-ones target constant.
package sha2_miner_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    RUN,
    CHECK,
    RELEASE
  } drv_state_t;

  localparam logic [255:0] TARGET_ALL_ONES = '1;

  function automatic int unsigned padded_bits(input int unsigned msg_bits);
    return ((msg_bits + 65 + 511) / 512) * 512;
  endfunction

endpackage

// File: rtl/sha256_pad.sv
// sha256_pad: builds {prefix, nonce, 1, zeros, 64-bit length}.
// Purely combinational; width is CHUNKS*512 bits, MSB first.
module sha256_pad #(
  parameter int PREFIX_BITS = 608,
  parameter int CHUNKS = 2,
  localparam int PW = (PREFIX_BITS > 0) ? PREFIX_BITS : 1
) (
  input  logic [PW-1:0]         prefix,
  input  logic [31:0]           nonce,
  output logic [CHUNKS*512-1:0] padded
);

  localparam int L = PREFIX_BITS + 32;
  localparam int W = CHUNKS * 512;

  logic [L-1:0] msg;

  if (PREFIX_BITS > 0) begin : g_prefix
    assign msg = {prefix, nonce};
  end else begin : g_no_prefix
    logic unused_prefix;
    assign unused_prefix = ^prefix;
    assign msg = nonce;
  end

  // message at the top, marker bit right after, length in the low 64 bits
  always_comb begin
    padded = '0;
    padded[W-1 -: L] = msg;
    padded[W-1-L] = 1'b1;
    padded[63:0] = 64'(L);
  end

endmodule

// File: rtl/sha256_nonce_driver.sv
// sha256_nonce_driver: sweeps a nonce range through one sha256 core.
// Define SHA256_DRIVER_STATS_EN to enable the hash_count counter.
module sha256_nonce_driver
  import sha2_miner_pkg::*;
#(
  parameter int PREFIX_BITS = 608,
  parameter int CHUNKS = 2,
  localparam int PW = (PREFIX_BITS > 0) ? PREFIX_BITS : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  job_valid,
  output logic                  job_ready,
  input  logic [PW-1:0]         job_prefix,
  input  logic [255:0]          job_target,
  input  logic [31:0]           nonce_first,
  input  logic [31:0]           nonce_last,
  input  logic                  abort,
  output logic                  core_start,
  output logic [CHUNKS*512-1:0] core_str,
  input  logic                  core_done,
  input  logic [255:0]          core_hash,
  output logic                  busy,
  output logic                  found_valid,
  output logic [31:0]           found_nonce,
  output logic [255:0]          found_hash,
  output logic                  exhausted,
  output logic [31:0]           hash_count
);

  localparam int W = CHUNKS * 512;

  drv_state_t    state;
  logic [PW-1:0] prefix_q;
  logic [255:0]  target_q;
  logic [255:0]  hash_q;
  logic [31:0]   nonce;
  logic [31:0]   last_q;
  logic          stop;
  logic          hit;
  logic          accept;
  logic [W-1:0]  padded;

  assign accept = job_valid && job_ready;

  if (padded_bits(PREFIX_BITS + 32) > W) begin : g_size_chk
    $error("sha256_nonce_driver: message does not fit in CHUNKS");
  end

  sha256_pad #(
    .PREFIX_BITS(PREFIX_BITS),
    .CHUNKS     (CHUNKS)
  ) u_pad (
    .prefix(prefix_q),
    .nonce (nonce),
    .padded(padded)
  );

  // job handshake, core handshake and result reporting
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      job_ready   <= 1'b0;
      busy        <= 1'b0;
      core_start  <= 1'b0;
      core_str    <= '0;
      found_valid <= 1'b0;
      found_nonce <= '0;
      found_hash  <= '0;
      exhausted   <= 1'b0;
      prefix_q    <= '0;
      target_q    <= '0;
      hash_q      <= '0;
      nonce       <= '0;
      last_q      <= '0;
      stop        <= 1'b0;
      hit         <= 1'b0;
    end else begin
      found_valid <= 1'b0;
      exhausted   <= 1'b0;
      unique case (state)
        IDLE: begin
          job_ready <= 1'b1;
          if (accept) begin
            prefix_q    <= job_prefix;
            target_q    <= job_target;
            last_q      <= nonce_last;
            nonce       <= nonce_first;
            found_nonce <= '0;
            found_hash  <= '0;
            stop        <= 1'b0;
            hit         <= 1'b0;
            if (nonce_first > nonce_last) begin
              exhausted <= 1'b1;
            end else begin
              job_ready <= 1'b0;
              busy      <= 1'b1;
              state     <= LOAD;
            end
          end
        end
        LOAD: begin
          core_str <= padded;
          if (abort) begin
            stop  <= 1'b1;
            state <= RELEASE;
          end else begin
            core_start <= 1'b1;
            state      <= RUN;
          end
        end
        RUN: begin
          if (abort) begin
            stop       <= 1'b1;
            core_start <= 1'b0;
            state      <= RELEASE;
          end else if (core_done) begin
            hash_q <= core_hash;
            state  <= CHECK;
          end
        end
        CHECK: begin
          core_start <= 1'b0;
          state      <= RELEASE;
          if (abort) stop <= 1'b1;
          if (hash_q <= target_q) begin
            hit         <= 1'b1;
            stop        <= 1'b1;
            found_valid <= 1'b1;
            found_nonce <= nonce;
            found_hash  <= hash_q;
          end
        end
        RELEASE: begin
          if (stop || nonce == last_q) begin
            state     <= IDLE;
            busy      <= 1'b0;
            job_ready <= 1'b1;
            exhausted <= !hit;
          end else begin
            nonce <= nonce + 32'd1;
            state <= LOAD;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SHA256_DRIVER_STATS_EN
  // saturating count of completed hashes for the current job
  always_ff @(posedge clk) begin
    if (reset) begin
      hash_count <= '0;
    end else if (state == IDLE && accept) begin
      hash_count <= '0;
    end else if (state == CHECK && hash_count != 32'hFFFF_FFFF) begin
      hash_count <= hash_count + 32'd1;
    end
  end
`else
  assign hash_count = '0;
`endif

endmodule

// File: tb/tb_sha256_nonce_driver.sv
// tb_sha256_nonce_driver: directed bench with a behavioural sha256 core
// and a reference sweep model; PREFIX_BITS=0, CHUNKS=1.
module tb_sha256_nonce_driver;

  localparam int CORE_LAT = 10;
  localparam logic [255:0] ONES = sha2_miner_pkg::TARGET_ALL_ONES;
  localparam logic [255:0] ABCD_HASH =
    256'h88d4266fd4e6338d13b845fcf289579d209c897823b9217da3e161936f031589;

  localparam logic [31:0] H0 [8] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};

  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

  logic         clk = 1'b0;
  logic         reset;
  logic         job_valid;
  logic         job_ready;
  logic [0:0]   job_prefix;
  logic [255:0] job_target;
  logic [31:0]  nonce_first;
  logic [31:0]  nonce_last;
  logic         abort;
  logic         core_start;
  logic [511:0] core_str;
  logic         core_done = 1'b0;
  logic [255:0] core_hash = '0;
  logic         busy;
  logic         found_valid;
  logic [31:0]  found_nonce;
  logic [255:0] found_hash;
  logic         exhausted;
  logic [31:0]  hash_count;

  int total = 0;
  int bad = 0;

  int nloads = 0;
  int found_cnt = 0;
  int exh_cnt = 0;
  int load_base = 0;
  int found_base = 0;
  int exh_base = 0;
  logic [31:0]  exp_first = '0;
  logic         start_d = 1'b0;
  logic [511:0] str_hold = '0;

  int   core_cnt = 0;
  logic core_run = 1'b0;

  sha256_nonce_driver #(
    .PREFIX_BITS(0),
    .CHUNKS     (1)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .job_valid  (job_valid),
    .job_ready  (job_ready),
    .job_prefix (job_prefix),
    .job_target (job_target),
    .nonce_first(nonce_first),
    .nonce_last (nonce_last),
    .abort      (abort),
    .core_start (core_start),
    .core_str   (core_str),
    .core_done  (core_done),
    .core_hash  (core_hash),
    .busy       (busy),
    .found_valid(found_valid),
    .found_nonce(found_nonce),
    .found_hash (found_hash),
    .exhausted  (exhausted),
    .hash_count (hash_count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [255:0] sha256_blk(input logic [511:0] blk);
    logic [31:0] w [64];
    logic [31:0] a, b, c, d, e, f, g, h, t1, t2;
    for (int t = 0; t < 16; t++) w[t] = blk[511-32*t -: 32];
    for (int t = 16; t < 64; t++)
      w[t] = (rotr(w[t-2], 17) ^ rotr(w[t-2], 19) ^ (w[t-2] >> 10))
           + w[t-7]
           + (rotr(w[t-15], 7) ^ rotr(w[t-15], 18) ^ (w[t-15] >> 3))
           + w[t-16];
    a = H0[0]; b = H0[1]; c = H0[2]; d = H0[3];
    e = H0[4]; f = H0[5]; g = H0[6]; h = H0[7];
    for (int t = 0; t < 64; t++) begin
      t1 = h + (rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25))
             + ((e & f) ^ (~e & g)) + K[t] + w[t];
      t2 = (rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22))
         + ((a & b) ^ (a & c) ^ (b & c));
      h = g; g = f; f = e; e = d + t1;
      d = c; c = b; b = a; a = t1 + t2;
    end
    return {a + H0[0], b + H0[1], c + H0[2], d + H0[3],
            e + H0[4], f + H0[5], g + H0[6], h + H0[7]};
  endfunction

  // one 512-bit block: nonce, 0x80 marker, zeros, bit length 32
  function automatic logic [511:0] pad_model(input logic [31:0] n);
    logic [511:0] m;
    m = '0;
    m[511:480] = n;
    m[479] = 1'b1;
    m[63:0] = 64'd32;
    return m;
  endfunction

  function automatic int exp_count(input int n);
`ifdef SHA256_DRIVER_STATS_EN
    return n;
`else
    return 0 * n;
`endif
  endfunction

  // reference sweep: hash nonces in order, stop at the first hit
  task automatic model_job(input logic [31:0] first, input logic [31:0] last,
                           input logic [255:0] tgt, output int nh,
                           output logic hit, output logic [31:0] hn,
                           output logic [255:0] hh);
    logic [255:0] hv;
    longint n;
    nh = 0; hit = 1'b0; hn = '0; hh = '0;
    n = longint'(first);
    while (n <= longint'(last) && !hit) begin
      hv = sha256_blk(pad_model(n[31:0]));
      nh++;
      if (hv <= tgt) begin
        hit = 1'b1; hn = n[31:0]; hh = hv;
      end
      n++;
    end
  endtask

  task automatic chk(input string name, input logic [511:0] act,
                     input logic [511:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  // behavioural core: done CORE_LAT cycles after start, cleared by start low
  always @(posedge clk) begin
    if (!core_start) begin
      core_run <= 1'b0;
      core_done <= 1'b0;
      core_cnt <= 0;
    end else if (!core_run && !core_done) begin
      core_run <= 1'b1;
      core_cnt <= 1;
    end else if (core_run) begin
      if (core_cnt >= CORE_LAT) begin
        core_run <= 1'b0;
        core_done <= 1'b1;
        core_hash <= sha256_blk(core_str);
      end else begin
        core_cnt <= core_cnt + 1;
      end
    end
  end

  // per-cycle compare against the expected nonce sequence
  always @(negedge clk) begin
    if (reset) begin
      start_d <= 1'b0;
    end else begin
      if (core_start && !start_d) begin
        chk("core_str", core_str,
            pad_model(exp_first + 32'(nloads - load_base)));
        str_hold <= core_str;
        nloads <= nloads + 1;
      end else if (core_start) begin
        chk("str_stable", core_str, str_hold);
      end
      if (!busy) chk("start_idle", 512'(core_start), 512'(0));
      if (found_valid) found_cnt <= found_cnt + 1;
      if (exhausted) exh_cnt <= exh_cnt + 1;
      start_d <= core_start;
    end
  end

  task automatic start_job(input logic [31:0] first, input logic [31:0] last,
                           input logic [255:0] tgt);
    int k;
    k = 0;
    while (!job_ready && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk("ready_wait", 512'(job_ready), 512'(1));
    exp_first = first;
    load_base = nloads;
    found_base = found_cnt;
    exh_base = exh_cnt;
    nonce_first = first;
    nonce_last = last;
    job_target = tgt;
    job_valid = 1'b1;
    @(posedge clk);
    #1 job_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int k;
    k = 0;
    @(negedge clk);
    while (busy && k < 5000) begin
      @(negedge clk);
      k++;
    end
    chk({name, "_idle"}, 512'(busy), 512'(0));
    @(negedge clk);
  endtask

  task automatic wait_start(input string name);
    int k;
    k = 0;
    while (!core_start && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk({name, "_start"}, 512'(core_start), 512'(1));
  endtask

  task automatic check_job(input string name, input logic [31:0] first,
                           input logic [31:0] last, input logic [255:0] tgt);
    int nh;
    logic hit;
    logic [31:0] hn;
    logic [255:0] hh;
    model_job(first, last, tgt, nh, hit, hn, hh);
    chk({name, "_loads"}, 512'(nloads - load_base), 512'(nh));
    chk({name, "_found"}, 512'(found_cnt - found_base), 512'(hit));
    chk({name, "_exh"}, 512'(exh_cnt - exh_base), 512'(!hit));
    chk({name, "_fnonce"}, 512'(found_nonce), 512'(hn));
    chk({name, "_fhash"}, 512'(found_hash), 512'(hh));
    chk({name, "_count"}, 512'(hash_count), 512'(exp_count(nh)));
    chk({name, "_ready"}, 512'(job_ready), 512'(1));
  endtask

  task automatic run_job(input string name, input logic [31:0] first,
                         input logic [31:0] last, input logic [255:0] tgt);
    start_job(first, last, tgt);
    wait_idle(name);
    check_job(name, first, last, tgt);
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, "_ready"}, 512'(job_ready), 512'(0));
    chk({name, "_busy"}, 512'(busy), 512'(0));
    chk({name, "_start"}, 512'(core_start), 512'(0));
    chk({name, "_str"}, core_str, 512'(0));
    chk({name, "_fv"}, 512'(found_valid), 512'(0));
    chk({name, "_fn"}, 512'(found_nonce), 512'(0));
    chk({name, "_fh"}, 512'(found_hash), 512'(0));
    chk({name, "_exh"}, 512'(exhausted), 512'(0));
    chk({name, "_cnt"}, 512'(hash_count), 512'(0));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [255:0] tgt8;
    reset = 1'b1;
    job_valid = 1'b0;
    job_prefix = '0;
    job_target = '0;
    nonce_first = '0;
    nonce_last = '0;
    abort = 1'b0;

    chk("model_abcd", 512'(sha256_blk(pad_model(32'h61626364))),
        512'(ABCD_HASH));

    repeat (3) @(negedge clk);
    chk_all_zero("rst");
    reset = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", 512'(job_ready), 512'(1));

    // single nonce "abcd", every hash is a hit
    run_job("t1", 32'h61626364, 32'h61626364, ONES);
    chk("t1_str_nonce", 512'(str_hold[511:480]), 512'(32'h61626364));
    chk("t1_str_mark", 512'(str_hold[479:472]), 512'(8'h80));
    chk("t1_str_zero", 512'(str_hold[471:64]), 512'(0));
    chk("t1_str_len", 512'(str_hold[63:0]), 512'(64'h20));
    chk("t1_hash_lit", 512'(found_hash), 512'(ABCD_HASH));

    // empty range: immediate exhausted, core untouched, found cleared
    start_job(32'd5, 32'd4, ONES);
    @(negedge clk);
    chk("t3_exh_next", 512'(exhausted), 512'(1));
    chk("t3_start", 512'(core_start), 512'(0));
    chk("t3_fh_clr", 512'(found_hash), 512'(0));
    repeat (3) @(negedge clk);
    check_job("t3", 32'd5, 32'd4, ONES);

    // no hit over 0..3
    run_job("t2", 32'd0, 32'd3, 256'd0);

    // abort while the core is running
    start_job(32'h10, 32'h20, 256'd0);
    wait_start("t4");
    repeat (2) @(negedge clk);
    abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    @(negedge clk);
    chk("t4_start_low", 512'(core_start), 512'(0));
    wait_idle("t4");
    chk("t4_loads", 512'(nloads - load_base), 512'(1));
    chk("t4_exh", 512'(exh_cnt - exh_base), 512'(1));
    chk("t4_found", 512'(found_cnt - found_base), 512'(0));
    chk("t4_count", 512'(hash_count), 512'(exp_count(0)));
    run_job("t4b", 32'h61626364, 32'h61626364, ONES);

    // top of the nonce space, no wrap
    run_job("t5", 32'hFFFF_FFFE, 32'hFFFF_FFFF, 256'd0);

    // abort in the same cycle as a hit is being checked
    start_job(32'h61626364, 32'h61626369, ONES);
    begin
      int k;
      k = 0;
      while (!core_done && k < 50) begin
        @(negedge clk);
        k++;
      end
      chk("t7_done", 512'(core_done), 512'(1));
    end
    @(negedge clk);
    abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    wait_idle("t7");
    check_job("t7", 32'h61626364, 32'h61626364, ONES);

    // reset in the middle of a run, then a normal job
    start_job(32'd0, 32'd3, 256'd0);
    wait_start("t6");
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk_all_zero("t6");
    reset = 1'b0;
    @(negedge clk);
    chk("t6_ready", 512'(job_ready), 512'(1));
    tgt8 = sha256_blk(pad_model(32'd102));
    run_job("t8", 32'd100, 32'd110, tgt8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
